// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions that retire in
// program order. Results arrive out of order through the writeback port,
// retired results go to the register file one per cycle, and a mispredicted
// branch at the head flushes the whole buffer and redirects fetch.
//
// Issue handshake: an issue is accepted on a rising edge where
// rdy && issue_valid && !full && !rollback. There is no back-pressure other
// than full and rollback; an issue presented while either is high is dropped
// and must be re-presented by the producer. alloc_rob_id names the id the
// next accepted issue receives.
module rob #(
  parameter int ROB_SZ = 16,
  localparam int ID_W  = $clog2(ROB_SZ),
  localparam int CNT_W = ID_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  // issue
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [31:0]     issue_pc,
  input  logic            issue_is_branch,
  input  logic            issue_pred_taken,
  input  logic            issue_ready,
  input  logic [31:0]     issue_data,
  output logic            full,
  output logic [ID_W-1:0] alloc_rob_id,
  // writeback
  input  logic            wb_valid,
  input  logic [ID_W-1:0] wb_rob_id,
  input  logic [31:0]     wb_data,
  input  logic            wb_taken,
  input  logic [31:0]     wb_target,
  // operand queries
  input  logic [ID_W-1:0] qry1_id,
  output logic            qry1_ready,
  output logic [31:0]     qry1_data,
  input  logic [ID_W-1:0] qry2_id,
  output logic            qry2_ready,
  output logic [31:0]     qry2_data,
  // commit to register file
  output logic            is_commit,
  output logic [4:0]      commit_rd,
  output logic [31:0]     commit_data,
  output logic [ID_W-1:0] commit_rob_id,
  // misprediction recovery
  output logic            rollback,
  output logic [31:0]     rollback_pc
);

  // Per-entry control flags (reset) and payload (no reset needed).
  logic [ROB_SZ-1:0] e_busy;
  logic [ROB_SZ-1:0] e_ready;
  logic [4:0]        e_rd         [ROB_SZ];
  logic [31:0]       e_data       [ROB_SZ];
  logic [31:0]       e_pc         [ROB_SZ];
  logic              e_is_branch  [ROB_SZ];
  logic              e_pred_taken [ROB_SZ];
  logic              e_taken      [ROB_SZ];
  logic [31:0]       e_target     [ROB_SZ];

  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  tail;
  logic [CNT_W-1:0] count;

  logic issue_fire;
  logic wb_fire;
  logic retire;
  logic head_mispred;
  logic rb_fire;

  // Circular increment; works for any ROB_SZ, not only powers of two.
  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(ROB_SZ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Occupancy, allocation and per-cycle event decode.
  always_comb begin
    full         = (count == CNT_W'(ROB_SZ));
    alloc_rob_id = tail;
    issue_fire   = issue_valid && !full && !rollback;
    wb_fire      = wb_valid && e_busy[wb_rob_id];
    retire       = (count != '0) && e_ready[head];
    head_mispred = e_is_branch[head] && (e_taken[head] != e_pred_taken[head]);
    rb_fire      = retire && head_mispred;
  end

  // Operand query 1: stored state, overridden by a same-cycle writeback.
  always_comb begin
    qry1_ready = e_ready[qry1_id];
    qry1_data  = e_data[qry1_id];
    if (wb_valid && (wb_rob_id == qry1_id)) begin
      qry1_ready = 1'b1;
      qry1_data  = wb_data;
    end
  end

  // Operand query 2: identical to query 1.
  always_comb begin
    qry2_ready = e_ready[qry2_id];
    qry2_data  = e_data[qry2_id];
    if (wb_valid && (wb_rob_id == qry2_id)) begin
      qry2_ready = 1'b1;
      qry2_data  = wb_data;
    end
  end

  // Queue pointers, occupancy and per-entry busy/ready flags.
  // A writeback only sets ready in the register, so the head cannot retire
  // on the same edge its result arrives; an issue is written after the
  // writeback so it wins when both target the (previously free) tail entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_busy  <= '0;
      e_ready <= '0;
    end else if (rdy) begin
      if (rb_fire) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        e_busy  <= '0;
        e_ready <= '0;
      end else begin
        if (wb_fire) begin
          e_ready[wb_rob_id] <= 1'b1;
        end
        if (retire) begin
          e_busy[head] <= 1'b0;
          head         <= nxt(head);
        end
        if (issue_fire) begin
          e_busy[tail]  <= 1'b1;
          e_ready[tail] <= issue_ready;
          tail          <= nxt(tail);
        end
        case ({issue_fire, retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload: writeback results, then issue fields (issue wins).
  always_ff @(posedge clk) begin
    if (!rst && rdy && !rb_fire) begin
      if (wb_fire) begin
        e_data[wb_rob_id]   <= wb_data;
        e_taken[wb_rob_id]  <= wb_taken;
        e_target[wb_rob_id] <= wb_target;
      end
      if (issue_fire) begin
        e_rd[tail]         <= issue_rd;
        e_pc[tail]         <= issue_pc;
        e_is_branch[tail]  <= issue_is_branch;
        e_pred_taken[tail] <= issue_pred_taken;
        e_data[tail]       <= issue_data;
        e_taken[tail]      <= 1'b0;
      end
    end
  end

  // Registered retire outputs: commit pulse for results, rollback pulse for
  // mispredicted branches. Data fields hold when nothing retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_commit     <= 1'b0;
      commit_rd     <= '0;
      commit_data   <= '0;
      commit_rob_id <= '0;
      rollback      <= 1'b0;
      rollback_pc   <= '0;
    end else if (rdy) begin
      is_commit <= 1'b0;
      rollback  <= 1'b0;
      if (retire) begin
        if (e_is_branch[head]) begin
          commit_rd <= '0;
          if (head_mispred) begin
            rollback    <= 1'b1;
            rollback_pc <= e_taken[head] ? e_target[head] : (e_pc[head] + 32'd4);
          end
        end else begin
          is_commit     <= 1'b1;
          commit_rd     <= e_rd[head];
          commit_data   <= e_data[head];
          commit_rob_id <= head;
        end
      end
    end
  end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL expose parameter ROB_SZ, default 16, number of entries; ROB id width is log2(ROB_SZ) = 4.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global enable; when low all state and outputs hold.
REQ-005 SHALL have issue ports: issue_valid in 1; issue_rd in 5; issue_pc in 32; issue_is_branch in 1; issue_pred_taken in 1; issue_ready in 1 (result known at issue); issue_data in 32.
REQ-006 SHALL have ports full out 1 (no free entry) and alloc_rob_id out 4 (id the next issue receives, equals tail).
REQ-007 SHALL have writeback ports: wb_valid in 1; wb_rob_id in 4; wb_data in 32; wb_taken in 1; wb_target in 32.
REQ-008 SHALL have query ports: qry1_id in 4, qry1_ready out 1, qry1_data out 32; qry2_id/qry2_ready/qry2_data identical.
REQ-009 SHALL have commit ports to the register file: is_commit out 1; commit_rd out 5; commit_data out 32; commit_rob_id out 4.
REQ-010 SHALL have ports rollback out 1 and rollback_pc out 32.

Function
REQ-011 Each entry SHALL hold busy, ready, rd, data, pc, is_branch, pred_taken, taken, target; circular buffer with head, tail (4 bits) and count (0..16).
REQ-012 full SHALL be combinational: count == ROB_SZ.
REQ-013 Issue: issue_valid && !full && !rollback -> entry[tail] written (busy=1, ready=issue_ready, data=issue_data, taken=0), tail = tail+1 mod 16; issue while full or while rollback high is dropped.
REQ-014 Writeback: wb_valid && entry[wb_rob_id].busy -> ready=1, data=wb_data, taken=wb_taken, target=wb_target; wb to a non-busy entry ignored.
REQ-015 Query SHALL be combinational: ready/data of entry[qry_id]; when wb_valid && wb_rob_id==qry_id same cycle, return ready=1 and wb_data (bypass).
REQ-016 Commit: at each edge, if count>0 and entry[head].ready, head retires: busy=0, head = head+1 mod 16; at most one retire per cycle.
REQ-017 Retire of non-branch SHALL register is_commit=1, commit_rd=rd, commit_data=data, commit_rob_id=head for exactly one cycle; otherwise is_commit=0.
REQ-018 Retire of branch SHALL register is_commit=0 and commit_rd=0; if taken == pred_taken no further action.
REQ-019 Mispredicted branch retire SHALL register rollback=1 for one cycle and rollback_pc = taken ? target : pc+4 (32-bit wrap).
REQ-020 On the edge where rollback is registered high, all entries SHALL be cleared in the same edge: busy=0, head=tail=0, count=0; subsequent issue resumes at id 0.
REQ-021 Simultaneous issue and retire SHALL leave count unchanged; issue alone +1, retire alone -1.
REQ-022 Issue to an entry and writeback to the same id in the same cycle: issue data wins (entry was not busy before).
REQ-023 Writeback of the head entry SHALL not retire the same edge; earliest retire is the following edge (one-cycle wb-to-commit latency).
REQ-024 Issue with issue_ready=1 at head of empty ROB SHALL retire on the next edge.
REQ-025 Head and tail SHALL wrap 15 -> 0 without loss; count distinguishes full from empty when head==tail.

Reset
REQ-026 rst high at edge SHALL set head=tail=count=0, all busy=0 and ready=0, is_commit=0, commit_rd=0, commit_data=0, commit_rob_id=0, rollback=0, rollback_pc=0; rst takes priority over rdy and all inputs.
REQ-027 rst asserted mid-operation SHALL discard all in-flight entries; no commit or rollback pulse emitted in the reset cycle or after.

Verification
REQ-028 Issue rd=5 issue_ready=0; next cycle wb id 0 data 0x1234 -> two edges later is_commit=1, commit_rd=5, commit_data=0x1234, commit_rob_id=0, one cycle only.
REQ-029 Issue 16 entries no wb -> full=1, 17th issue dropped, alloc_rob_id=0; then wb id 0 -> retire, full=0 next cycle.
REQ-030 Issue ids 0..2, wb in order 2,1,0 -> commits emitted ids 0,1,2 in consecutive cycles, never out of order.
REQ-031 Branch pc=0x100 pred_taken=0, wb taken=1 target=0x200, younger entries present -> rollback=1, rollback_pc=0x200, count=0, alloc_rob_id=0, no is_commit for younger entries.
REQ-032 Query id 3 while wb id 3 data 0xBEEF same cycle -> qry1_ready=1, qry1_data=0xBEEF; rdy low two cycles during pending retire -> outputs hold, retire occurs after rdy returns.
